// File: rtl/alu_arbiter_pkg.sv
// Shared types and constants for alu_arbiter and its alu.
package alu_arbiter_pkg;

   localparam int unsigned DATA_W_DEF = 32;
   localparam int unsigned OP_W_DEF   = 3;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_e;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_SRA = 3'b101;
   localparam logic [2:0] OP_SLL = 3'b110;
   localparam logic [2:0] OP_SRL = 3'b111;

endpackage

// File: rtl/alu_arbiter_alu.sv
// Combinational ALU (A, B, ALUOp -> C) shared through alu_arbiter.
module alu
   import alu_arbiter_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEF,
   parameter int unsigned OP_W   = OP_W_DEF
) (
   input  logic [DATA_W-1:0] A,
   input  logic [DATA_W-1:0] B,
   input  logic [OP_W-1:0]   ALUOp,
   output logic [DATA_W-1:0] C
);

   localparam int unsigned SH_W = $clog2(DATA_W);

   logic [SH_W-1:0] shamt;
   logic [2:0]      op3;

   assign shamt = B[SH_W-1:0];
   assign op3   = 3'(ALUOp);

   always_comb begin
      C = '0;
      case (op3)
         OP_ADD:  C = A + B;
         OP_SUB:  C = A - B;
         OP_AND:  C = A & B;
         OP_OR:   C = A | B;
         OP_XOR:  C = A ^ B;
         OP_SRA:  C = $unsigned($signed(A) >>> shamt);
         OP_SLL:  C = A << shamt;
         default: C = A >> shamt;
      endcase
   end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one alu between two valid/ready requesters.
// Define ALU_ARB_STATS_EN to add saturating per-requester grant counters.
module alu_arbiter
   import alu_arbiter_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEF,
   parameter int unsigned OP_W   = OP_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [1:0]        req_valid,
   output logic [1:0]        req_ready,
   input  logic [DATA_W-1:0] req0_a,
   input  logic [DATA_W-1:0] req0_b,
   input  logic [OP_W-1:0]   req0_op,
   input  logic [DATA_W-1:0] req1_a,
   input  logic [DATA_W-1:0] req1_b,
   input  logic [OP_W-1:0]   req1_op,
   output logic [1:0]        resp_valid,
   input  logic [1:0]        resp_ready,
   output logic [DATA_W-1:0] resp_data,
   output logic              busy
`ifdef ALU_ARB_STATS_EN
   ,
   output logic [15:0]       gnt_cnt0,
   output logic [15:0]       gnt_cnt1
`endif
);

   state_e            state_q;
   logic              prio_q;
   logic              gnt_q;
   logic [DATA_W-1:0] a_q, b_q, resp_data_q;
   logic [OP_W-1:0]   op_q;
   logic [1:0]        resp_valid_q;
   logic              busy_q;

   logic              gnt_d;
   logic [DATA_W-1:0] a_d, b_d;
   logic [OP_W-1:0]   op_d;
   logic              accept;
   logic [DATA_W-1:0] alu_c;

   // A lone requester wins outright; prio only breaks ties.
   always_comb begin
      gnt_d = prio_q;
      if (req_valid == 2'b01)
         gnt_d = 1'b0;
      else if (req_valid == 2'b10)
         gnt_d = 1'b1;
      a_d    = gnt_d ? req1_a  : req0_a;
      b_d    = gnt_d ? req1_b  : req0_b;
      op_d   = gnt_d ? req1_op : req0_op;
      accept = !reset && (state_q == ST_IDLE) && (req_valid != 2'b00);
      req_ready = '0;
      if (accept)
         req_ready = gnt_d ? 2'b10 : 2'b01;
   end

   alu #(.DATA_W(DATA_W), .OP_W(OP_W)) u_alu (
      .A     (a_q),
      .B     (b_q),
      .ALUOp (op_q),
      .C     (alu_c)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         prio_q       <= 1'b0;
         gnt_q        <= 1'b0;
         a_q          <= '0;
         b_q          <= '0;
         op_q         <= '0;
         resp_data_q  <= '0;
         resp_valid_q <= '0;
         busy_q       <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  a_q     <= a_d;
                  b_q     <= b_d;
                  op_q    <= op_d;
                  gnt_q   <= gnt_d;
                  prio_q  <= ~gnt_d;
                  busy_q  <= 1'b1;
                  state_q <= ST_EXEC;
               end
            end
            ST_EXEC: begin
               resp_data_q  <= alu_c;
               resp_valid_q <= gnt_q ? 2'b10 : 2'b01;
               state_q      <= ST_RESP;
            end
            ST_RESP: begin
               if (resp_ready[gnt_q]) begin
                  resp_valid_q <= '0;
                  busy_q       <= 1'b0;
                  state_q      <= ST_IDLE;
               end
            end
            default: begin
               resp_valid_q <= '0;
               busy_q       <= 1'b0;
               state_q      <= ST_IDLE;
            end
         endcase
      end
   end

   assign resp_valid = resp_valid_q;
   assign resp_data  = resp_data_q;
   assign busy       = busy_q;

`ifdef ALU_ARB_STATS_EN
   logic [15:0] cnt0_q, cnt1_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt0_q <= '0;
         cnt1_q <= '0;
      end else if (accept) begin
         if (!gnt_d && cnt0_q != 16'hFFFF)
            cnt0_q <= cnt0_q + 16'd1;
         if (gnt_d && cnt1_q != 16'hFFFF)
            cnt1_q <= cnt1_q + 16'd1;
      end
   end

   assign gnt_cnt0 = cnt0_q;
   assign gnt_cnt1 = cnt1_q;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios plus random traffic against a transaction-level model.
module tb_alu_arbiter;
   import alu_arbiter_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  req_valid, req_ready, resp_valid, resp_ready;
   logic [31:0] req0_a, req0_b, req1_a, req1_b, resp_data;
   logic [2:0]  req0_op, req1_op;
   logic        busy;
`ifdef ALU_ARB_STATS_EN
   logic [15:0] gnt_cnt0, gnt_cnt1;
`endif

   always #5 clk = ~clk;

   alu_arbiter #(.DATA_W(32), .OP_W(3)) dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req0_a     (req0_a),
      .req0_b     (req0_b),
      .req0_op    (req0_op),
      .req1_a     (req1_a),
      .req1_b     (req1_b),
      .req1_op    (req1_op),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_data  (resp_data),
      .busy       (busy)
`ifdef ALU_ARB_STATS_EN
      ,
      .gnt_cnt0   (gnt_cnt0),
      .gnt_cnt1   (gnt_cnt1)
`endif
   );

   int n_pass  = 0;
   int n_total = 0;

   // requester-side pending requests
   logic [1:0]  pend;
   logic [31:0] pa [2];
   logic [31:0] pb [2];
   logic [2:0]  pop [2];

   // transaction-level model: one transaction in flight, timed from its accept
   bit          m_act;
   int          m_since;
   bit          m_own;
   bit          m_prio;
   logic [31:0] m_res;
   int          gcnt [2];

   function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                           input logic [2:0] op);
      int unsigned sh;
      logic [31:0] r;
      sh = int'(b & 32'd31);
      case (op)
         3'd0: r = a + b;
         3'd1: r = a + (~b) + 32'd1;
         3'd2: r = a & b;
         3'd3: r = a | b;
         3'd4: r = a ^ b;
         3'd5: begin
            r = a >> sh;
            if (a[31] && sh != 0) r = r | ~(32'hFFFF_FFFF >> sh);
         end
         3'd6: r = a << sh;
         default: r = a >> sh;
      endcase
      return r;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic post(input int i, input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] op);
      pend[i] = 1'b1;
      pa[i]   = a;
      pb[i]   = b;
      pop[i]  = op;
   endtask

   task automatic drive_in();
      req_valid = pend;
      req0_a = pa[0]; req0_b = pb[0]; req0_op = pop[0];
      req1_a = pa[1]; req1_b = pb[1]; req1_op = pop[1];
   endtask

   // check one cycle's outputs against the model, then advance it over the edge
   task automatic tick();
      logic [1:0] exp_rr, exp_rv;
      logic       exp_busy;
      bit         w;
      drive_in();
      #1;
      if (!m_act) begin
         exp_busy = 1'b0;
         exp_rv   = 2'b00;
         if (pend == 2'b11) exp_rr = m_prio ? 2'b10 : 2'b01;
         else               exp_rr = pend;
      end else begin
         exp_busy = 1'b1;
         exp_rr   = 2'b00;
         exp_rv   = (m_since >= 2) ? (m_own ? 2'b10 : 2'b01) : 2'b00;
      end
      chk("req_ready", 32'(req_ready), 32'(exp_rr));
      chk("busy", 32'(busy), 32'(exp_busy));
      chk("resp_valid", 32'(resp_valid), 32'(exp_rv));
      if (m_act && m_since >= 2) chk("resp_data", resp_data, m_res);
      if (!m_act) begin
         if (pend != 2'b00) begin
            w       = exp_rr[1];
            m_act   = 1'b1;
            m_since = 1;
            m_own   = w;
            m_res   = ref_alu(pa[w], pb[w], pop[w]);
            pend[w] = 1'b0;
            m_prio  = !w;
            gcnt[w]++;
         end
      end else if (m_since == 1) begin
         m_since = 2;
      end else if (resp_ready[m_own]) begin
         m_act = 1'b0;
      end
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      pend  = '0;
      drive_in();
      @(negedge clk);
      reset   = 1'b0;
      m_act   = 1'b0;
      m_since = 0;
      m_prio  = 1'b0;
      gcnt[0] = 0;
      gcnt[1] = 0;
   endtask

   initial begin
      logic [31:0] held;
      pend = '0;
      for (int i = 0; i < 2; i++) begin
         pa[i] = '0; pb[i] = '0; pop[i] = '0;
      end
      resp_ready = '0;
      reset      = 1'b1;
      drive_in();
      @(negedge clk);
      do_reset();

      // reset state
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_resp_valid", 32'(resp_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_resp_data", resp_data, 32'd0);

      // single ADD from requester 0
      post(0, 32'd5, 32'd3, OP_ADD);
      resp_ready = 2'b01;
      drive_in(); #1;
      chk("add_req_ready", 32'(req_ready), 32'h1);
      tick();
      tick();
      chk("add_resp_valid", 32'(resp_valid), 32'h1);
      chk("add_resp_data", resp_data, 32'd8);
      tick();
      chk("add_busy_drop", 32'(busy), 32'd0);

      // both continuously valid: grants alternate 0,1,0,1
      do_reset();
      resp_ready = 2'b11;
      for (int g = 0; g < 4; g++) begin
         for (int c = 0; c < 3; c++) begin
            if (!pend[0]) post(0, 32'd10, 32'd4, OP_SUB);
            if (!pend[1]) post(1, 32'hF000_0000, 32'd4, OP_SRA);
            if (c == 2) begin
               chk("alt_resp_valid", 32'(resp_valid), (g % 2 == 1) ? 32'h2 : 32'h1);
               chk("alt_resp_data", resp_data, (g % 2 == 1) ? 32'hFF00_0000 : 32'd6);
            end
            tick();
         end
      end

      // stall in RESP, then wrong-bit ready must not release requester 0
      do_reset();
      post(0, 32'h1234_5678, 32'h0F0F_0F0F, OP_XOR);
      post(1, 32'd100, 32'd1, OP_SUB);
      resp_ready = 2'b00;
      tick();
      tick();
      held = resp_data;
      for (int k = 0; k < 5; k++) begin
         chk("stall_data_stable", resp_data, held);
         tick();
      end
      resp_ready = 2'b10;
      for (int k = 0; k < 2; k++) begin
         chk("wrong_bit_resp_valid", 32'(resp_valid), 32'h1);
         tick();
      end
      resp_ready = 2'b01;
      tick();
      resp_ready = 2'b11;
      for (int k = 0; k < 3; k++) tick();

      // reset while in EXEC drops the transaction and clears prio
      do_reset();
      post(1, 32'd7, 32'd9, OP_ADD);
      resp_ready = 2'b11;
      tick();
      do_reset();
      drive_in(); #1;
      chk("rst_exec_busy", 32'(busy), 32'd0);
      chk("rst_exec_resp_valid", 32'(resp_valid), 32'd0);
      tick();
      post(0, 32'd1, 32'd2, OP_OR);
      post(1, 32'd3, 32'd4, OP_AND);
      drive_in(); #1;
      chk("rst_exec_prio", 32'(req_ready), 32'h1);
      for (int k = 0; k < 6; k++) tick();

      // grant sequence 0,1,0,1,0 for the counters
      do_reset();
      for (int g = 0; g < 5; g++) begin
         post(g % 2, 32'(g), 32'd1, OP_SLL);
         for (int c = 0; c < 3; c++) tick();
      end
`ifdef ALU_ARB_STATS_EN
      chk("gnt_cnt0", 32'(gnt_cnt0), 32'd3);
      chk("gnt_cnt1", 32'(gnt_cnt1), 32'd2);
`endif

      // random traffic
      for (int n = 0; n < 600; n++) begin
         for (int i = 0; i < 2; i++)
            if (!pend[i] && $urandom_range(0, 2) == 0)
               post(i, $urandom, $urandom, 3'($urandom_range(0, 7)));
         resp_ready = 2'($urandom);
         tick();
      end
`ifdef ALU_ARB_STATS_EN
      chk("rand_gnt_cnt0", 32'(gnt_cnt0), 32'(gcnt[0]));
      chk("rand_gnt_cnt1", 32'(gnt_cnt1), 32'(gcnt[1]));
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
